// File: rtl/wb_unit.sv
// wb_unit: writeback stage that retires ALU, CSR and load results into the register file.
// Loads wait for memory data, with a timeout, before the write or a load fault.
module wb_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rd_en,
    input  logic [4:0]  req_rd,
    input  logic [1:0]  req_src,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] alu_result,
    input  logic [31:0] csr_val,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        done,
    output logic        load_fault,
    output logic        pend_valid,
    output logic [4:0]  pend_rd
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          rd_en_q;
    logic [4:0]    rd_q;
    logic [2:0]    f3_q;
    logic [1:0]    alo_q;
    logic [31:0]   data_q;
    logic          accept, legal, load_ok, expired, wr_ok;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   ext;

    assign accept  = state == IDLE && req_valid;
    assign legal   = f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign load_ok = !mem_err && legal;
    assign expired = cnt == CW'(TIMEOUT);
    assign wr_ok   = rd_en_q && rd_q != 5'd0;
    assign byte_v  = alo_q[1] ? (alo_q[0] ? mem_rdata[31:24] : mem_rdata[23:16])
                              : (alo_q[0] ? mem_rdata[15:8]  : mem_rdata[7:0]);
    assign half_v  = alo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ext     = f3_q == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                     f3_q == 3'b001 ? {{16{half_v[15]}}, half_v} :
                     f3_q == 3'b010 ? mem_rdata :
                     f3_q == 3'b100 ? {24'd0, byte_v} : {16'd0, half_v};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = !req_valid ? IDLE : req_src == 2'b01 ? WAIT_MEM : WRITE;
            WAIT_MEM: state_nx = mem_rvalid ? (load_ok ? WRITE : IDLE) : (expired ? IDLE : WAIT_MEM);
            default:  state_nx = IDLE;
        endcase
    end

    // Data arriving in the expiry cycle still completes: mem_rvalid is tested before expired.
    always_comb begin
        req_ready  = state == IDLE;
        done       = state == WRITE;
        rf_we      = done && wr_ok;
        rf_rd      = rf_we ? rd_q : 5'd0;
        rf_wdata   = rf_we ? data_q : 32'd0;
        load_fault = state == WAIT_MEM && (mem_rvalid ? !load_ok : expired);
        pend_valid = state != IDLE && wr_ok;
        pend_rd    = pend_valid ? rd_q : 5'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            rd_en_q <= 1'b0;
            rd_q    <= 5'd0;
            f3_q    <= 3'd0;
            alo_q   <= 2'd0;
            data_q  <= 32'd0;
        end else begin
            cnt <= state == WAIT_MEM ? cnt + 1'b1 : '0;
            if (accept) begin
                rd_en_q <= req_rd_en;
                rd_q    <= req_rd;
                f3_q    <= req_funct3;
                alo_q   <= req_addr_lo;
                data_q  <= req_src == 2'b10 ? csr_val : alu_result;
            end
            if (state == WAIT_MEM && mem_rvalid && load_ok) data_q <= ext;
        end
    end
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: directed vector table plus hand-written timeout, reset and back-to-back sequences.
module tb_wb_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_rd_en;
    logic [4:0]  req_rd;
    logic [1:0]  req_src, req_addr_lo;
    logic [2:0]  req_funct3;
    logic [31:0] alu_result, csr_val, mem_rdata, rf_wdata;
    logic        mem_rvalid, mem_err, rf_we, done, load_fault, pend_valid;
    logic [4:0]  rf_rd, pend_rd;

    int checks = 0;
    int errors = 0;

    wb_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rd_en(req_rd_en), .req_rd(req_rd), .req_src(req_src), .req_funct3(req_funct3),
        .req_addr_lo(req_addr_lo), .alu_result(alu_result), .csr_val(csr_val),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .done(done),
        .load_fault(load_fault), .pend_valid(pend_valid), .pend_rd(pend_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic        rd_en;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] alu;
        logic [31:0] csr;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] wdata;
        logic        fault;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input logic [1:0] src, input logic rd_en, input logic [4:0] rd,
                             input logic [2:0] f3, input logic [1:0] alo,
                             input logic [31:0] alu, input logic [31:0] csr);
        req_valid = 1'b1; req_src = src; req_rd_en = rd_en; req_rd = rd;
        req_funct3 = f3; req_addr_lo = alo; alu_result = alu; csr_val = csr;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic wr, pend;
        wr   = v.rd_en && v.rd != 5'd0 && !v.fault;
        pend = v.rd_en && v.rd != 5'd0;
        @(negedge clk);
        drive_req(v.src, v.rd_en, v.rd, v.f3, v.alo, v.alu, v.csr);
        #1 chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.src == 2'b01) begin
            mem_rvalid = 1'b1; mem_rdata = v.rdata; mem_err = v.err;
            #1 chk($sformatf("v%0d load_fault", idx), 32'(load_fault), 32'(v.fault));
            chk($sformatf("v%0d wait pend_valid", idx), 32'(pend_valid), 32'(pend));
            @(negedge clk);
            mem_rvalid = 1'b0; mem_err = 1'b0;
        end
        #1;
        if (v.fault) begin
            chk($sformatf("v%0d fault rf_we", idx), 32'(rf_we), 32'd0);
            chk($sformatf("v%0d fault done", idx), 32'(done), 32'd0);
            chk($sformatf("v%0d fault req_ready", idx), 32'(req_ready), 32'd1);
        end else begin
            chk($sformatf("v%0d rf_we", idx), 32'(rf_we), 32'(wr));
            chk($sformatf("v%0d rf_rd", idx), 32'(rf_rd), wr ? 32'(v.rd) : 32'd0);
            chk($sformatf("v%0d rf_wdata", idx), rf_wdata, wr ? v.wdata : 32'd0);
            chk($sformatf("v%0d done", idx), 32'(done), 32'd1);
            chk($sformatf("v%0d pend_valid", idx), 32'(pend_valid), 32'(pend));
            chk($sformatf("v%0d pend_rd", idx), 32'(pend_rd), pend ? 32'(v.rd) : 32'd0);
        end
    endtask

    task automatic load_wait(input logic data_at_expiry);
        @(negedge clk);
        drive_req(2'b01, 1'b1, 5'd6, 3'b010, 2'd0, 32'd0, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (k == 4 && data_at_expiry) begin
                mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0F0F; mem_err = 1'b0;
            end
            #1;
            chk($sformatf("to%0d k%0d load_fault", data_at_expiry, k), 32'(load_fault),
                32'(k == 4 && !data_at_expiry));
            chk($sformatf("to%0d k%0d pend_valid", data_at_expiry, k), 32'(pend_valid), 32'd1);
            chk($sformatf("to%0d k%0d rf_we", data_at_expiry, k), 32'(rf_we), 32'd0);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk($sformatf("to%0d after rf_we", data_at_expiry), 32'(rf_we), 32'(data_at_expiry));
        chk($sformatf("to%0d after rf_wdata", data_at_expiry), rf_wdata,
            data_at_expiry ? 32'hA5A5_0F0F : 32'd0);
        chk($sformatf("to%0d after req_ready", data_at_expiry), 32'(req_ready), 32'(!data_at_expiry));
        chk($sformatf("to%0d after load_fault", data_at_expiry), 32'(load_fault), 32'd0);
    endtask

    initial begin
        // src, rd_en, rd, f3, alo, alu, csr, rdata, err, expected wdata, expected fault
        vt[0]  = '{2'b00, 1'b1, 5'd5,  3'b000, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 32'h1234_5678, 1'b0};
        vt[1]  = '{2'b10, 1'b1, 5'd7,  3'b000, 2'd0, 32'h1111_1111, 32'hCAFE_BABE, 32'h0, 1'b0, 32'hCAFE_BABE, 1'b0};
        vt[2]  = '{2'b11, 1'b1, 5'd9,  3'b000, 2'd0, 32'hDEAD_BEEF, 32'h2222_2222, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vt[3]  = '{2'b00, 1'b1, 5'd0,  3'b000, 2'd0, 32'h0000_0055, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0};
        vt[4]  = '{2'b00, 1'b0, 5'd3,  3'b000, 2'd0, 32'h0000_0077, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0};
        vt[5]  = '{2'b01, 1'b1, 5'd10, 3'b000, 2'd3, 32'h0, 32'h0, 32'h80FF_0011, 1'b0, 32'hFFFF_FF80, 1'b0};
        vt[6]  = '{2'b01, 1'b1, 5'd11, 3'b101, 2'd2, 32'h0, 32'h0, 32'h80FF_0011, 1'b0, 32'h0000_80FF, 1'b0};
        vt[7]  = '{2'b01, 1'b1, 5'd31, 3'b010, 2'd0, 32'h0, 32'h0, 32'h80FF_0011, 1'b0, 32'h80FF_0011, 1'b0};
        vt[8]  = '{2'b01, 1'b1, 5'd12, 3'b100, 2'd2, 32'h0, 32'h0, 32'h80FF_0011, 1'b0, 32'h0000_00FF, 1'b0};
        vt[9]  = '{2'b01, 1'b1, 5'd13, 3'b001, 2'd3, 32'h0, 32'h0, 32'h80FF_0011, 1'b0, 32'hFFFF_80FF, 1'b0};
        vt[10] = '{2'b01, 1'b1, 5'd14, 3'b000, 2'd1, 32'h0, 32'h0, 32'h0000_8000, 1'b0, 32'hFFFF_FF80, 1'b0};
        vt[11] = '{2'b01, 1'b1, 5'd15, 3'b001, 2'd0, 32'h0, 32'h0, 32'h0000_8001, 1'b0, 32'hFFFF_8001, 1'b0};
        vt[12] = '{2'b01, 1'b1, 5'd16, 3'b010, 2'd0, 32'h0, 32'h0, 32'h1234_5678, 1'b1, 32'h0, 1'b1};
        vt[13] = '{2'b01, 1'b1, 5'd17, 3'b011, 2'd0, 32'h0, 32'h0, 32'h1234_5678, 1'b0, 32'h0, 1'b1};
        vt[14] = '{2'b01, 1'b1, 5'd18, 3'b110, 2'd0, 32'h0, 32'h0, 32'h1234_5678, 1'b0, 32'h0, 1'b1};

        rst_n = 1'b0; req_valid = 1'b0; req_rd_en = 1'b0; req_rd = 5'd0; req_src = 2'b00;
        req_funct3 = 3'd0; req_addr_lo = 2'd0; alu_result = 32'd0; csr_val = 32'd0;
        mem_rvalid = 1'b0; mem_rdata = 32'd0; mem_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset outputs", {rf_we, done, load_fault, pend_valid, rf_rd, pend_rd}, 32'd0);
        chk("reset rf_wdata", rf_wdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(i, vt[i]);

        load_wait(1'b0);
        load_wait(1'b1);

        // stray mem_rvalid while idle
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1 chk("idle rvalid rf_we", 32'(rf_we), 32'd0);
        chk("idle rvalid req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1 chk("idle rvalid after", {rf_we, done, load_fault, pend_valid}, 32'd0);

        // reset during WAIT_MEM, then late data
        @(negedge clk);
        drive_req(2'b01, 1'b1, 5'd20, 3'b010, 2'd0, 32'd0, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("rstwait pend_valid pre", 32'(pend_valid), 32'd1);
        rst_n = 1'b0;
        #1 chk("rstwait req_ready", 32'(req_ready), 32'd1);
        chk("rstwait pend_valid", 32'(pend_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1 chk("rstwait rf_we", 32'(rf_we), 32'd0);
        chk("rstwait done", 32'(done), 32'd0);
        chk("rstwait ready", 32'(req_ready), 32'd1);

        // reset during WRITE suppresses the write
        @(negedge clk);
        drive_req(2'b00, 1'b1, 5'd21, 3'b000, 2'd0, 32'h0BAD_F00D, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk("rstwrite rf_we", 32'(rf_we), 32'd0);
        chk("rstwrite done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back: req_valid held high across two requests
        @(negedge clk);
        drive_req(2'b00, 1'b1, 5'd22, 3'b000, 2'd0, 32'hAAAA_0001, 32'd0);
        @(negedge clk);
        alu_result = 32'hBBBB_0002; req_rd = 5'd23;
        #1 chk("b2b first wdata", rf_wdata, 32'hAAAA_0001);
        chk("b2b first busy", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1 chk("b2b gap rf_we", 32'(rf_we), 32'd0);
        chk("b2b gap ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("b2b second wdata", rf_wdata, 32'hBBBB_0002);
        chk("b2b second rd", 32'(rf_rd), 32'd23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
